// File: rtl/pixel_readout_pkg.sv
// pixel_readout_pkg: shared types and constants for the pixel readout stage.
//   - state_e      : readout FSM state encoding
//   - DEF_*        : default parameter values for pixel_readout
//   - idx_width()  : width of an index counter over n items (at least 1 bit)
package pixel_readout_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        CAPTURE = 3'd2,
        SHIFT   = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int DEF_N_ROWS     = 2;
    localparam int DEF_N_COLS     = 2;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_SETTLE_CYC = 2;

    // Index width over n items; a single item still needs a 1-bit counter.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_readout_gray2bin.sv
// gray2bin: purely combinational Gray-to-binary converter for one pixel field.
// Ports:
//   gray_i : DATA_W-bit Gray-coded input
//   bin_o  : DATA_W-bit binary output
module gray2bin #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] gray_i,
    output logic [DATA_W-1:0] bin_o
);

    // Each binary bit is the XOR of every Gray bit at or above its position.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/pixel_readout.sv
// pixel_readout: row-by-row readout of a pixel array. On start it selects each
// row, waits SETTLE_CYC cycles, latches the row-parallel ADC bus and streams the
// row one pixel per valid/ready beat with frame (sof) and line (eol) markers.
// done pulses for one cycle after the last beat of the frame is accepted.
// Optional build macro PIXEL_READOUT_GRAY_EN: row_data fields are Gray code and
// are converted to binary on their way into the row latch.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin frame readout (ignored unless idle)
//   row_en, row_sel     : row select to the array
//   row_data            : row-parallel ADC codes, column c at [c*DATA_W +: DATA_W]
//   out_data/valid/ready: pixel stream; out_sof/out_eol frame/line markers
//   busy, done          : status
module pixel_readout
    import pixel_readout_pkg::*;
#(
    parameter int N_ROWS     = DEF_N_ROWS,
    parameter int N_COLS     = DEF_N_COLS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       row_en,
    output logic [idx_width(N_ROWS)-1:0] row_sel,
    input  logic [N_COLS*DATA_W-1:0]   row_data,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sof,
    output logic                       out_eol,
    output logic                       busy,
    output logic                       done
);

    localparam int RW = idx_width(N_ROWS);
    localparam int CW = idx_width(N_COLS);
    localparam int SW = idx_width(SETTLE_CYC);

    localparam logic [RW-1:0] LAST_ROW    = RW'(N_ROWS - 1);
    localparam logic [CW-1:0] LAST_COL    = CW'(N_COLS - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYC - 1);

    state_e                   state_q;
    logic [RW-1:0]            row_q;
    logic [CW-1:0]            col_q;
    logic [CW-1:0]            col_d;
    logic [SW-1:0]            settle_q;
    logic [N_COLS*DATA_W-1:0] latch_q;
    logic [N_COLS*DATA_W-1:0] capture_d;

    logic                     row_en_q;
    logic [DATA_W-1:0]        out_data_q;
    logic                     out_valid_q;
    logic                     out_sof_q;
    logic                     out_eol_q;
    logic                     busy_q;
    logic                     done_q;

    assign col_d = col_q + CW'(1);

`ifdef PIXEL_READOUT_GRAY_EN
    for (genvar c = 0; c < N_COLS; c++) begin : g_gray
        gray2bin #(.DATA_W(DATA_W)) u_gray2bin (
            .gray_i (row_data[c*DATA_W +: DATA_W]),
            .bin_o  (capture_d[c*DATA_W +: DATA_W])
        );
    end
`else
    assign capture_d = row_data;
`endif

    // Readout FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            settle_q    <= '0;
            latch_q     <= '0;
            row_en_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= SELECT;
                        row_q    <= '0;
                        settle_q <= '0;
                        row_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                SELECT: begin
                    settle_q <= settle_q + SW'(1);
                    if (settle_q == LAST_SETTLE) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // The first beat is loaded from the bus directly, in the same
                    // edge that fills the latch, so SHIFT presents it immediately.
                    latch_q     <= capture_d;
                    col_q       <= '0;
                    state_q     <= SHIFT;
                    row_en_q    <= 1'b0;
                    out_valid_q <= 1'b1;
                    out_data_q  <= capture_d[DATA_W-1:0];
                    out_sof_q   <= (row_q == '0);
                    out_eol_q   <= (LAST_COL == '0);
                end
                SHIFT: begin
                    if (out_ready) begin
                        if (col_q == LAST_COL) begin
                            out_valid_q <= 1'b0;
                            out_sof_q   <= 1'b0;
                            out_eol_q   <= 1'b0;
                            if (row_q != LAST_ROW) begin
                                row_q    <= row_q + RW'(1);
                                settle_q <= '0;
                                row_en_q <= 1'b1;
                                state_q  <= SELECT;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end else begin
                            col_q      <= col_d;
                            out_data_q <= latch_q[col_d*DATA_W +: DATA_W];
                            out_sof_q  <= 1'b0;
                            out_eol_q  <= (col_d == LAST_COL);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    row_en_q    <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign row_en    = row_en_q;
    assign row_sel   = row_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pixel_readout.sv
// tb_pixel_readout: self-checking bench for pixel_readout at default parameters.
// The array is modelled by driving row_data from the selected row; expected
// beats come from a frame-level model (all rows, all columns, markers).
module tb_pixel_readout;
    import pixel_readout_pkg::*;

    localparam int NR = DEF_N_ROWS;
    localparam int NC = DEF_N_COLS;
    localparam int DW = DEF_DATA_W;
    localparam int SC = DEF_SETTLE_CYC;
    localparam int RW = idx_width(NR);

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           row_en;
    logic [RW-1:0]  row_sel;
    logic [NC*DW-1:0] row_data;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_sof;
    logic           out_eol;
    logic           busy;
    logic           done;

    pixel_readout #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .SETTLE_CYC(SC)) dut (
        .clk(clk), .reset(reset), .start(start), .row_en(row_en), .row_sel(row_sel),
        .row_data(row_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Array model: the selected row is on the bus; with garble set the bus
    // carries all-ones except in the cycle the row should be captured.
    logic [NC*DW-1:0] rows [NR];
    bit               garble = 1'b0;
    int               en_cnt = 0;

    always @(posedge clk) en_cnt <= row_en ? en_cnt + 1 : 0;

    always_comb begin
        row_data = rows[row_sel];
        if (garble && !(row_en && en_cnt == SC)) row_data = '1;
    end

    // Pixel value model: with Gray input, find the binary code whose Gray form matches.
    function automatic logic [DW-1:0] pix_model(input logic [DW-1:0] f);
`ifdef PIXEL_READOUT_GRAY_EN
        logic [DW-1:0] b;
        for (int v = 0; v < (1 << DW); v++) begin
            b = DW'(v);
            if ((b ^ (b >> 1)) == f) return b;
        end
        return '0;
`else
        return f;
`endif
    endfunction

    logic [DW+1:0] got_q[$];
    logic [DW+1:0] exp_q[$];
    int en_runs[$];
    int sel_seq[$];
    int first_valid_k, last_beat_k, done_k, done_cnt;

    task automatic build_exp();
        exp_q.delete();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                exp_q.push_back({pix_model(rows[r][c*DW +: DW]), 1'((r == 0) && (c == 0)), 1'(c == NC - 1)});
    endtask

    // One frame: mode 0 ready=1, mode 1 stall 5 cycles on beat 1, mode 2 random ready.
    // restart pulses start again while busy and in the done cycle.
    task automatic run_frame(input int mode, input bit restart);
        int run, stall, tail;
        bit prev_stall;
        logic [DW+1:0] prev;
        got_q.delete(); en_runs.delete(); sel_seq.delete();
        first_valid_k = -1; last_beat_k = -1; done_k = -1; done_cnt = 0;
        run = 0; stall = 0; tail = -1; prev_stall = 1'b0; prev = '0;
        build_exp();
        for (int k = 0; k < 500; k++) begin
            if (k > 0) @(negedge clk);
            else @(negedge clk);
            start = (k == 0) || (restart && (k == 6 || done));
            case (mode)
                1: out_ready = !(out_valid && got_q.size() == 1 && stall < 5);
                2: out_ready = ($urandom % 4) != 0;
                default: out_ready = 1'b1;
            endcase
            if (!out_ready && mode == 1) stall++;
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_beat", 32'({out_data, out_sof, out_eol}), 32'(prev));
            end
            prev_stall = out_valid && !out_ready;
            prev = {out_data, out_sof, out_eol};
            if (row_en) begin
                if (run == 0) sel_seq.push_back(int'(row_sel));
                run++;
            end else if (run != 0) begin
                en_runs.push_back(run);
                run = 0;
            end
            if (out_valid && first_valid_k < 0) first_valid_k = k;
            if (out_valid && out_ready) begin
                got_q.push_back({out_data, out_sof, out_eol});
                last_beat_k = k;
            end
            if (done) begin
                done_cnt++;
                done_k = k;
                if (tail < 0) tail = k;
            end
            if (tail >= 0 && k >= tail + 4) break;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("frame_finished", 32'(tail >= 0), 32'd1);
        chk("beat_count", 32'(got_q.size()), 32'(NR * NC));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("beat%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        chk("first_valid_lat", 32'(first_valid_k), 32'(SC + 2));
        chk("done_after_last", 32'(done_k), 32'(last_beat_k + 1));
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("row_en_runs", 32'(en_runs.size()), 32'(NR));
        for (int i = 0; i < en_runs.size(); i++) chk("row_en_len", 32'(en_runs[i]), 32'(SC + 1));
        for (int i = 0; i < sel_seq.size(); i++) chk("row_sel_seq", 32'(sel_seq[i]), 32'(i));
        chk("busy_end", 32'(busy), 32'd0);
        chk("valid_end", 32'(out_valid), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row_en"}, 32'(row_en), 32'd0);
        chk({tag, "_row_sel"}, 32'(row_sel), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_sof"}, 32'(out_sof), 32'd0);
        chk({tag, "_eol"}, 32'(out_eol), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    typedef struct packed {
        logic [15:0] r0;
        logic [15:0] r1;
        logic [31:0] exp;   // beat j in [j*8 +: 8]
    } vec_t;

    vec_t vt [3];
    int   n_vec;

    initial begin
`ifdef PIXEL_READOUT_GRAY_EN
        vt[0] = '{r0: 16'h8003, r1: 16'h0100, exp: 32'h0100FF02};
        vt[1] = '{r0: 16'h0000, r1: 16'h0302, exp: 32'h02030000};
        n_vec = 2;
`else
        vt[0] = '{r0: 16'h2211, r1: 16'h4433, exp: 32'h44332211};
        vt[1] = '{r0: 16'h00FF, r1: 16'h8001, exp: 32'h800100FF};
        vt[2] = '{r0: 16'hA55A, r1: 16'h0F0F, exp: 32'h0F0FA55A};
        n_vec = 3;
`endif
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        rows[0] = '0; rows[1] = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        // Table-driven frames.
        for (int i = 0; i < n_vec; i++) begin
            rows[0] = vt[i].r0; rows[1] = vt[i].r1;
            run_frame(0, 1'b0);
            for (int j = 0; j < 4 && j < got_q.size(); j++)
                chk($sformatf("table%0d_beat%0d", i, j), 32'(got_q[j][DW+1:2]), 32'(vt[i].exp[j*8 +: 8]));
        end

        // Backpressure on the second beat.
        rows[0] = 16'h2211; rows[1] = 16'h4433;
        run_frame(1, 1'b0);

        // Bus garbage outside the capture cycle.
        garble = 1'b1;
        run_frame(0, 1'b0);
        garble = 1'b0;

        // start while busy and during the done cycle.
        run_frame(0, 1'b1);

        // Reset during the second row's select phase, then a fresh frame.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 100 && !(row_en && row_sel == RW'(1)); k++) @(negedge clk);
        chk("reach_row1_select", 32'(row_en && row_sel == RW'(1)), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_no_done", 32'(done), 32'd0);
        run_frame(0, 1'b0);

        // Random rows with random backpressure.
        for (int i = 0; i < 8; i++) begin
            rows[0] = 16'($urandom); rows[1] = 16'($urandom);
            run_frame(2, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
